serial_frame_receiver: RTL and testbench
========================================

# serial_frame_receiver

Downstream consumer of the serial-in/serial-out delay register's `serial_out` line. It frames the one-bit-per-clock stream, deserialises each frame into a `DATA_W`-bit word, and checks the stop bit (and parity, when compiled in). Each good word is held in a one-entry output buffer and presented to the parallel side on a valid/ready handshake.

## Interface
- `DATA_W`, default 8: data bits per frame; legal values 2–32.
- `clk` in 1: rising-edge clock; every edge samples one serial bit.
- `reset` in 1: asynchronous, active-low; 0 clears all state immediately.
- `serial_in` in 1: serial line from the upstream shift register. Idle level is 0, which matches the upstream reset value.
- `data_ready` in 1: consumer accepts the word when `data_valid && data_ready` at a rising edge.
- `data_out` out DATA_W: received word, LSB = first data bit on the line.
- `data_valid` out 1: `data_out` holds an unaccepted word.
- `frame_err` out 1: one-cycle pulse; stop bit was not 0.
- `parity_err` out 1: one-cycle pulse; parity mismatch. Tied 0 when parity is compiled out.
- `overrun` out 1: one-cycle pulse; a good frame was dropped because the buffer was full.

## Operation
- Frame on the line: start bit (1), `DATA_W` data bits (LSB first), optional even-parity bit, stop bit (0).
- FSM states:
  - IDLE: `serial_in=1` → DATA, with bit counter = 0. Otherwise stay in IDLE.
  - DATA: shift `serial_in` into shift register bit `[cnt]` and increment `cnt`. After `cnt=DATA_W-1`, go to PARITY if compiled in, else STOP.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: always return to IDLE. Then evaluate, in this priority order:
    - stop bit = 1 → pulse `frame_err`, discard the word.
    - parity mismatch → pulse `parity_err`, discard the word.
    - otherwise → the word is good.
- Delivery of a good word:
  - Buffer empty, or being accepted at this same edge: load `data_out`, `data_valid=1`.
  - Buffer full and not accepted at this edge: keep the old word, pulse `overrun`, drop the new word.
- Handshake: `data_valid` falls on the edge where `data_ready=1`, unless a new good word loads at that edge; then it stays 1 with the new `data_out`.
- `data_out` is stable while `data_valid=1` and not accepted. It keeps its last value after acceptance.
- A stop bit of 1 is never reinterpreted as a start bit. The FSM goes to IDLE and looks for a start bit on the next edge.
- Error pulses never change `data_valid` or `data_out`.
- Bit counter width is `$clog2(DATA_W)`.

## Timing
- Reset values:
  - outputs: `data_out=0`, `data_valid=0`, `frame_err=0`, `parity_err=0`, `overrun=0`.
  - internal: FSM in IDLE, counter 0, shift register 0.
- Reset mid-frame: the frame is aborted asynchronously and any buffered word is lost. The first sampling edge after release looks for a start bit.
- Latency, with the start bit sampled at edge T:
  - data bits are sampled at T+1 … T+DATA_W.
  - stop bit is sampled at T+DATA_W+1, or T+DATA_W+2 with parity.
  - `data_valid` and any error/overrun pulse are registered at that stop edge, so they are visible right after it.
- Back-to-back frames: the next start bit may be sampled at stop edge +1. Sustained throughput is one word per DATA_W+2 cycles (DATA_W+3 with parity).
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `SERIAL_RX_PARITY_EN`, defined:
  - the PARITY state exists and the frame is DATA_W+3 bits long.
  - even parity: XOR of the data bits and the parity bit must be 0.
  - mismatch pulses `parity_err` and discards the word.
- `SERIAL_RX_PARITY_EN`, undefined:
  - no PARITY state; the frame is DATA_W+2 bits long.
  - `parity_err` is constant 0.

## Test plan
All scenarios use DATA_W=8.
- **Reset values:** hold `reset=0`, toggle `serial_in` → all outputs 0; after release, idle 0s produce no activity.
- **Good frame:** start at edge T; data 0xA5 sent LSB first (1,0,1,0,0,1,0,1); stop 0; `data_ready=1` → `data_out=0xA5` and `data_valid=1` right after edge T+9, cleared after edge T+10.
- **Bad stop bit:** frame 0x3C with stop=1 → `frame_err` high for one cycle after the stop edge, `data_valid` stays 0. A valid frame starting 1 cycle later is received as 0x3C.
- **Overrun and release:**
  - frames 0x11 then 0x22 back-to-back, `data_ready=0` → `data_out=0x11` held, `overrun` pulses once at the second stop edge.
  - then `data_ready=1` → 0x11 accepted, `data_valid` falls.
  - good frame completing on the same edge as an acceptance → `data_valid` stays 1 with the new word, no overrun.
- **Parity (macro defined):**
  - 0x01 with parity bit 1 → accepted as 0x01.
  - 0x01 with parity bit 0 → `parity_err` pulse, no `data_valid`.
- **Reset mid-frame:** drop `reset` after 4 data bits, release, send 0x5A → only 0x5A is delivered, no error pulses.

Source files
------------

// File: rtl/serial_frame_receiver_if.sv
// Parallel/serial bundle of the frame receiver.
// slave  : receiver view (samples serial_in/data_ready, drives word + status).
// master : upstream line / parallel consumer view.
interface serial_frame_receiver_if #(
   parameter int DATA_W = 8
);
   logic              serial_in;
   logic              data_ready;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              frame_err;
   logic              parity_err;
   logic              overrun;

   modport master (
      output serial_in, data_ready,
      input  data_out, data_valid, frame_err, parity_err, overrun
   );

   modport slave (
      input  serial_in, data_ready,
      output data_out, data_valid, frame_err, parity_err, overrun
   );
endinterface

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start(1), DATA_W data bits LSB first, optional even
// parity bit, stop(0). Good words go to a one-entry buffer on valid/ready.
// Optional feature macro: SERIAL_RX_PARITY_EN (adds the parity bit/state).
module serial_frame_receiver #(
   parameter int DATA_W = 8
) (
   input logic                   clk,
   input logic                   reset,
   serial_frame_receiver_if.slave bus
);
   localparam int CNT_W = $clog2(DATA_W);

`ifdef SERIAL_RX_PARITY_EN
   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP} state_t;
`endif

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [DATA_W-1:0] shift_q, shift_nxt;
   logic              stop_edge;
   logic              par_bad;
   logic              good;

   logic [DATA_W-1:0] dout_q;
   logic              dvalid_q;
   logic              ferr_q;
   logic              ovr_q;
   logic              accept;

`ifdef SERIAL_RX_PARITY_EN
   logic              par_q, par_nxt;
   logic              perr_q;
`endif

   // Frame FSM and deserialiser state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         shift_q <= '0;
`ifdef SERIAL_RX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         shift_q <= shift_nxt;
`ifdef SERIAL_RX_PARITY_EN
         par_q   <= par_nxt;
`endif
      end
   end

   // Next-state: hunt start bit, shift data bits, (parity), stop
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      shift_nxt = shift_q;
      stop_edge = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_nxt   = par_q;
`endif
      case (state)
         S_IDLE: begin
            if (bus.serial_in) begin
               state_nxt = S_DATA;
               cnt_nxt   = '0;
            end
         end
         S_DATA: begin
            shift_nxt[cnt] = bus.serial_in;
            cnt_nxt        = cnt + CNT_W'(1);
            if (cnt == CNT_W'(DATA_W - 1)) begin
`ifdef SERIAL_RX_PARITY_EN
               state_nxt = S_PARITY;
`else
               state_nxt = S_STOP;
`endif
            end
         end
`ifdef SERIAL_RX_PARITY_EN
         S_PARITY: begin
            par_nxt   = bus.serial_in;
            state_nxt = S_STOP;
         end
`endif
         S_STOP: begin
            // A high stop bit is not a start bit: always drop back to IDLE.
            stop_edge = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Frame verdict at the stop edge; frame error outranks parity error
   always_comb begin
`ifdef SERIAL_RX_PARITY_EN
      par_bad = (^shift_q) ^ par_q;
`else
      par_bad = 1'b0;
`endif
      good   = stop_edge && !bus.serial_in && !par_bad;
      accept = dvalid_q && bus.data_ready;
   end

   // One-entry output buffer and registered status pulses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dout_q   <= '0;
         dvalid_q <= 1'b0;
         ferr_q   <= 1'b0;
         ovr_q    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
         perr_q   <= 1'b0;
`endif
      end else begin
         ferr_q <= stop_edge && bus.serial_in;
`ifdef SERIAL_RX_PARITY_EN
         perr_q <= stop_edge && !bus.serial_in && par_bad;
`endif
         ovr_q  <= 1'b0;
         if (good && (!dvalid_q || accept)) begin
            dout_q   <= shift_q;
            dvalid_q <= 1'b1;
         end else begin
            if (good) ovr_q <= 1'b1;     // full and not draining: drop new word
            if (accept) dvalid_q <= 1'b0;
         end
      end
   end

   assign bus.data_out   = dout_q;
   assign bus.data_valid = dvalid_q;
   assign bus.frame_err  = ferr_q;
   assign bus.overrun    = ovr_q;
`ifdef SERIAL_RX_PARITY_EN
   assign bus.parity_err = perr_q;
`else
   assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver (DATA_W=8): a frame-level vector
// table plus hand sequences for reset, pulse width, overrun and parity.
module tb_serial_frame_receiver;
   logic clk;
   logic reset;
   int   checks;
   int   failures;

   serial_frame_receiver_if #(.DATA_W(8)) bus ();

   serial_frame_receiver #(.DATA_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         gap;      // idle cycles before the frame, data_ready=1
      logic [7:0] d;
      logic       stop;
      logic       rdy;      // data_ready during start/data(/parity) bits
      logic       rdy_stop; // data_ready at the stop edge
      logic       ev;
      logic [7:0] ed;
      logic       ef;
      logic       eo;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick(input logic s, input logic r);
      bus.serial_in  = s;
      bus.data_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip,
                             input logic rdy, input logic rdy_stop);
      logic [7:0] dv;
      dv = d;
      tick(1'b1, rdy);
      for (int i = 0; i < 8; i++) tick(dv[i], rdy);
`ifdef SERIAL_RX_PARITY_EN
      tick((^dv) ^ pflip, rdy);
`else
      if (pflip) $display("note: parity flip ignored without parity");
`endif
      tick(stop, rdy_stop);
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                          input logic f, input logic p, input logic o);
      chk({tag, ".valid"},  bus.data_valid, v);
      chk({tag, ".data"},   bus.data_out,   d);
      chk({tag, ".ferr"},   bus.frame_err,  f);
      chk({tag, ".perr"},   bus.parity_err, p);
      chk({tag, ".ovr"},    bus.overrun,    o);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      vecs[0] = '{2, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{0, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0};
      vecs[2] = '{0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
      vecs[3] = '{1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
      vecs[4] = '{0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1};
      vecs[5] = '{0, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0};
      vecs[6] = '{2, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0};
      vecs[7] = '{0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0};
      vecs[8] = '{0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
      vecs[9] = '{0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};

      // Reset values, with the line toggling while held
      reset          = 1'b0;
      bus.serial_in  = 1'b0;
      bus.data_ready = 1'b0;
      for (int i = 0; i < 4; i++) tick(i[0], 1'b1);
      chk_out("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
      chk_out("idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Frame table
      for (int k = 0; k < 10; k++) begin
         for (int g = 0; g < vecs[k].gap; g++) tick(1'b0, 1'b1);
         send_frame(vecs[k].d, vecs[k].stop, 1'b0, vecs[k].rdy, vecs[k].rdy_stop);
         chk_out($sformatf("vec%0d", k), vecs[k].ev, vecs[k].ed, vecs[k].ef, 1'b0, vecs[k].eo);
      end

      // Latency/handshake: valid right after stop edge, cleared one edge later
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
      chk_out("good", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1);
      chk_out("good_acc", 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);

      // Frame error is a single-cycle pulse
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
      chk_out("ferr", 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0);
      chk_out("ferr_end", 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);

      // Overrun pulse is single-cycle, buffered word held, then released
      send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_out("ovr", 1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0);
      chk_out("ovr_end", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1);
      chk_out("ovr_rel", 1'b0, 8'h11, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_RX_PARITY_EN
      // Even parity: good bit accepted, flipped bit rejected
      send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_out("par_ok", 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
      send_frame(8'h01, 1'b0, 1'b1, 1'b1, 1'b1);
      chk_out("par_bad", 1'b0, 8'h01, 1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0);
      chk_out("par_end", 1'b0, 8'h01, 1'b0, 1'b0, 1'b0);
`endif

      // Reset mid-frame: buffered word and partial frame both lost
      send_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_out("pre_rst", 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      #2 reset = 1'b0;
      #1;
      chk_out("mid_rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick(1'b0, 1'b0);
         chk_out($sformatf("post_rst%0d", i), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      end
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_out("rx_5a", 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0);
      chk_out("rx_5a_hold", 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
